// File: rtl/cmos_pixel_packer_if.sv
// Sensor-side byte stream in, assembled pixel stream plus line/frame markers out.
interface cmos_pixel_packer_if #(
  parameter int IN_W          = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int X_W           = 12,
  parameter int Y_W           = 11
);
  logic                          i_vsync;
  logic                          i_de;
  logic [IN_W-1:0]               i_pdata;
  logic [IN_W*BYTES_PER_PIX-1:0] o_pix;
  logic                          o_pix_valid;
  logic [X_W-1:0]                o_x;
  logic [Y_W-1:0]                o_y;
  logic                          o_sol;
  logic                          o_sof;
  logic                          o_eol;
  logic [X_W-1:0]                o_line_len;
  logic                          o_err_partial;

  modport slave (
    input  i_vsync, i_de, i_pdata,
    output o_pix, o_pix_valid, o_x, o_y, o_sol, o_sof, o_eol, o_line_len, o_err_partial
  );
  modport master (
    output i_vsync, i_de, i_pdata,
    input  o_pix, o_pix_valid, o_x, o_y, o_sol, o_sof, o_eol, o_line_len, o_err_partial
  );
endinterface

// File: rtl/cmos_pixel_packer.sv
// DVP byte-to-pixel packer: gathers BYTES_PER_PIX bytes per pixel and tracks
// pixel/line coordinates, line ends, partial-pixel lines and frame starts.
module cmos_pixel_packer #(
  parameter int IN_W          = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int MSB_FIRST     = 1,
  parameter int X_W           = 12,
  parameter int Y_W           = 11
) (
  input  logic i_pclk,
  input  logic rst_n,
  cmos_pixel_packer_if.slave bus
);
  localparam int BCW = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(BYTES_PER_PIX - 1);
  localparam logic [X_W-1:0] XMAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ABORT} state_t;
  state_t r_state, w_next;

  logic                                r_vs_d;
  logic [BCW-1:0]                      r_bcnt;
  logic [X_W-1:0]                      r_xcnt;
  logic                                r_sof_pend;
  logic [BYTES_PER_PIX-1:0][IN_W-1:0]  r_acc, w_pix, r_pix;
  logic                                r_pix_valid, r_sol, r_sof, r_eol, r_err;
  logic [X_W-1:0]                      r_x, r_line_len;
  logic [Y_W-1:0]                      r_y;
  logic                                w_vs_rise, w_cap, w_last, w_eol;

  // vsync edge wins over everything else in the same cycle
  assign w_vs_rise = bus.i_vsync & ~r_vs_d;
  assign w_cap     = ~w_vs_rise & bus.i_de & (r_state != S_ABORT);
  assign w_last    = w_cap & (r_bcnt == LAST);
  assign w_eol     = ~w_vs_rise & ~bus.i_de & (r_state == S_ACTIVE);

  // Current byte merged into its lane; earlier lanes come from the accumulator
  for (genvar l = 0; l < BYTES_PER_PIX; l++) begin : g_lane
    localparam int K = (MSB_FIRST != 0) ? BYTES_PER_PIX - 1 - l : l;
    assign w_pix[l] = (r_bcnt == BCW'(K)) ? bus.i_pdata : r_acc[l];
  end

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_vs_rise) w_next = bus.i_de ? S_ABORT : S_IDLE;
    else begin
      case (r_state)
        S_IDLE:   if (bus.i_de)  w_next = S_ACTIVE;
        S_ACTIVE: if (!bus.i_de) w_next = S_IDLE;
        S_ABORT:  if (!bus.i_de) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d      <= 1'b0;
      r_bcnt      <= '0;
      r_xcnt      <= '0;
      r_sof_pend  <= 1'b0;
      r_acc       <= '0;
      r_pix       <= '0;
      r_pix_valid <= 1'b0;
      r_sol       <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_err       <= 1'b0;
      r_x         <= '0;
      r_line_len  <= '0;
      r_y         <= '0;
    end else begin
      r_vs_d      <= bus.i_vsync;
      r_pix_valid <= 1'b0;
      r_sol       <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_err       <= 1'b0;
      if (w_vs_rise) begin
        r_y        <= '0;
        r_bcnt     <= '0;
        r_xcnt     <= '0;
        r_sof_pend <= 1'b1;
      end else begin
        // line index advances in the cycle o_eol is visible
        if (r_eol) r_y <= r_y + 1'b1;
        if (w_last) begin
          r_pix       <= w_pix;
          r_pix_valid <= 1'b1;
          r_x         <= r_xcnt;
          r_sol       <= (r_xcnt == '0);
          r_sof       <= r_sof_pend;
          r_sof_pend  <= 1'b0;
          r_xcnt      <= (r_xcnt == XMAX) ? r_xcnt : r_xcnt + 1'b1;
          r_bcnt      <= '0;
        end else if (w_cap) begin
          r_acc  <= w_pix;
          r_bcnt <= r_bcnt + 1'b1;
        end
        if (w_eol) begin
          r_eol      <= 1'b1;
          r_line_len <= r_xcnt;
          r_err      <= (r_bcnt != '0);
          r_xcnt     <= '0;
          r_bcnt     <= '0;
        end
      end
    end
  end

  assign bus.o_pix         = r_pix;
  assign bus.o_pix_valid   = r_pix_valid;
  assign bus.o_x           = r_x;
  assign bus.o_y           = r_y;
  assign bus.o_sol         = r_sol;
  assign bus.o_sof         = r_sof;
  assign bus.o_eol         = r_eol;
  assign bus.o_line_len    = r_line_len;
  assign bus.o_err_partial = r_err;
endmodule
